// File: rtl/zap_ram_ben_rd_fe.sv
// zap_ram_ben_rd_fe: credit-based read front-end for zap_ram_simple_ben with an in-order response FIFO.
// Define ZAP_RAM_RD_FE_FAST_EN to capture the 2-cycle pre-output (LAT=2) instead of the 3-cycle output.
module zap_ram_ben_rd_fe #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 32,
    parameter int FIFO_DEPTH = 8,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_flush,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [AW-1:0]    i_req_addr,
    output logic             o_ram_clken,
    output logic [AW-1:0]    o_ram_rd_addr,
    input  logic [WIDTH-1:0] i_ram_rd_data,
    input  logic [WIDTH-1:0] i_ram_rd_data_pre,
`ifdef ZAP_RAM_RD_FE_FAST_EN
    input  logic             i_ram_wr_en,
    input  logic [AW-1:0]    i_ram_wr_addr,
`endif
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [WIDTH-1:0] o_rsp_data,
    output logic             o_busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    logic [WIDTH-1:0] cap_data;
`ifdef ZAP_RAM_RD_FE_FAST_EN
    localparam int LAT = 2;
    logic unused_rd_data;
    assign cap_data = i_ram_rd_data_pre;
    assign unused_rd_data = ^i_ram_rd_data;
`else
    localparam int LAT = 3;
    logic unused_rd_data_pre;
    assign cap_data = i_ram_rd_data;
    assign unused_rd_data_pre = ^i_ram_rd_data_pre;
`endif
    logic [LAT-1:0]   vld;
    logic [PW-1:0]    wptr, rptr;
    logic [CW-1:0]    occ, occ_nxt, fcnt;
    logic             rdy, accept, pop, push;
    logic [WIDTH-1:0] mem [FIFO_DEPTH];

    assign o_ram_clken   = 1'b1;
    assign o_ram_rd_addr = i_req_addr;
    assign o_req_ready   = rdy & ~i_flush;
    assign accept        = i_req_valid & o_req_ready;
    assign o_rsp_valid   = fcnt != '0;
    assign o_rsp_data    = o_rsp_valid ? mem[rptr] : '0;
    assign o_busy        = occ != '0;
    assign pop           = o_rsp_valid & i_rsp_ready & ~i_flush;
    assign push          = vld[LAT-1] & ~i_flush;
    // occupancy is the credit count: in-flight reads plus buffered responses
    assign occ_nxt       = i_flush ? '0 : occ + CW'(accept) - CW'(pop);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            vld  <= '0;
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
            fcnt <= '0;
            rdy  <= 1'b0;
        end else begin
            occ <= occ_nxt;
            rdy <= occ_nxt < CW'(FIFO_DEPTH);
            if (i_flush) begin
                vld  <= '0;
                wptr <= '0;
                rptr <= '0;
                fcnt <= '0;
            end else begin
                vld  <= {vld[LAT-2:0], accept};
                wptr <= wptr + PW'(push);
                rptr <= rptr + PW'(pop);
                fcnt <= fcnt + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem[wptr] <= cap_data;
    end

    assert property (@(posedge i_clk) disable iff (i_reset) !(push && fcnt == CW'(FIFO_DEPTH)));

`ifdef ZAP_RAM_RD_FE_FAST_EN
    // the pre-output misses writes landing in the final RAM stage, so the requester must avoid them
    logic [AW-1:0] addr_q [LAT];
    always_ff @(posedge i_clk) begin
        addr_q[0] <= i_req_addr;
        for (int i = 1; i < LAT; i++) addr_q[i] <= addr_q[i-1];
    end
    assert property (@(posedge i_clk) disable iff (i_reset)
        !(vld[LAT-1] && i_ram_wr_en && i_ram_wr_addr == addr_q[LAT-1]));
`endif
endmodule
